max_fp_window_pool: RTL

Streaming floating-point max-pooling unit for the VGG16 pooling layers. It accepts LANES independent IEEE-754 channels, one sample per lane per valid cycle. Over every WINDOW consecutive valid samples it keeps a running maximum per lane, then emits one registered result per lane. It sits between the ReLU output of a conv block and the feature-map buffer, and replaces combinational 2/4-input max trees with a sequential, window-configurable accumulator.

---
 rtl/max_fp_window_pool_if.sv | 28 ++
 rtl/max_fp_window_pool.sv | 113 +++++++++++
 2 files changed

// File: rtl/max_fp_window_pool_if.sv
`default_nettype none
// ============================================================================
// Module   : max_fp_window_pool_if
// Brief    : Streaming sample/result bundle for max_fp_window_pool.
//            o_index exists only when MAX_POOL_ARGMAX_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface max_fp_window_pool_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int IDX_WIDTH  = 2
);
  logic                        i_valid;
  logic                        i_flush;
  logic [LANES*DATA_WIDTH-1:0] i_data;
  logic                        o_valid;
  logic [LANES*DATA_WIDTH-1:0] o_max;
`ifdef MAX_POOL_ARGMAX_EN
  logic [LANES*IDX_WIDTH-1:0]  o_index;

  modport master (output i_valid, i_flush, i_data, input o_valid, o_max, o_index);
  modport slave  (input i_valid, i_flush, i_data, output o_valid, o_max, o_index);
`else
  modport master (output i_valid, i_flush, i_data, input o_valid, o_max);
  modport slave  (input i_valid, i_flush, i_data, output o_valid, o_max);
`endif
endinterface
`default_nettype wire

// File: rtl/max_fp_window_pool.sv
`default_nettype none
// ============================================================================
// Module   : max_fp_window_pool
// Brief    : Per-lane running max of IEEE-754 words over WINDOW valid samples.
//            Define MAX_POOL_ARGMAX_EN to add per-lane argmax index tracking.
// Revision : 1.0 - initial release
// ============================================================================
module max_fp_window_pool #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int WINDOW     = 4,
  parameter int IDX_WIDTH  = (WINDOW > 1) ? $clog2(WINDOW) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  max_fp_window_pool_if.slave  bus
);
  localparam int                   BUS_W    = LANES * DATA_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LAST_CNT = IDX_WIDTH'(WINDOW - 1);

  logic [IDX_WIDTH-1:0] cnt_q, cnt_d, base_cnt;
  logic [BUS_W-1:0]     acc_q, acc_d;
  logic                 valid_q, valid_d;
  logic [BUS_W-1:0]     max_q, max_d;
`ifdef MAX_POOL_ARGMAX_EN
  logic [LANES*IDX_WIDTH-1:0] idx_q, idx_d;
  logic [LANES*IDX_WIDTH-1:0] oidx_q, oidx_d;
`endif

  // Strict "a > b"; signed zeros compare equal so a tie keeps the earlier sample.
  function automatic logic greater(input logic [DATA_WIDTH-1:0] a,
                                   input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-2:0] ma;
    logic [DATA_WIDTH-2:0] mb;
    logic                  res;
    ma  = a[DATA_WIDTH-2:0];
    mb  = b[DATA_WIDTH-2:0];
    res = 1'b0;
    if ((ma == '0) && (mb == '0))
      res = 1'b0;
    else if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1])
      res = ~a[DATA_WIDTH-1];
    else if (!a[DATA_WIDTH-1])
      res = (ma > mb);
    else
      res = (ma < mb);
    return res;
  endfunction

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    valid_d  = 1'b0;
    max_d    = max_q;
`ifdef MAX_POOL_ARGMAX_EN
    idx_d    = idx_q;
    oidx_d   = oidx_q;
`endif
    base_cnt = bus.i_flush ? '0 : cnt_q;
    if (bus.i_flush)
      cnt_d = '0;
    if (bus.i_valid) begin
      for (int k = 0; k < LANES; k++) begin
        if ((base_cnt == '0) ||
            greater(bus.i_data[k*DATA_WIDTH +: DATA_WIDTH], acc_q[k*DATA_WIDTH +: DATA_WIDTH])) begin
          acc_d[k*DATA_WIDTH +: DATA_WIDTH] = bus.i_data[k*DATA_WIDTH +: DATA_WIDTH];
`ifdef MAX_POOL_ARGMAX_EN
          idx_d[k*IDX_WIDTH +: IDX_WIDTH] = base_cnt;
`endif
        end
      end
      if (base_cnt == LAST_CNT) begin
        valid_d = 1'b1;
        max_d   = acc_d;
        cnt_d   = '0;
`ifdef MAX_POOL_ARGMAX_EN
        oidx_d  = idx_d;
`endif
      end else begin
        cnt_d = base_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      max_q   <= '0;
`ifdef MAX_POOL_ARGMAX_EN
      idx_q   <= '0;
      oidx_q  <= '0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
      max_q   <= max_d;
`ifdef MAX_POOL_ARGMAX_EN
      idx_q   <= idx_d;
      oidx_q  <= oidx_d;
`endif
    end
  end

  assign bus.o_valid = valid_q;
  assign bus.o_max   = max_q;
`ifdef MAX_POOL_ARGMAX_EN
  assign bus.o_index = oidx_q;
`endif
endmodule
`default_nettype wire
